fpu_issue_scoreboard: RTL and testbench

//  Core-side initiator for fpu_float. Replaces the trace-replay stimulus with real issue logic.

---
 rtl/fpu_issue_scoreboard.sv | 142 ++++++++++++++
 tb/tb_fpu_issue_scoreboard.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_issue_scoreboard.sv
// Issue scoreboard between FP decode, fpu_float and the FP regfile: RAW/WAW hazard blocking,
// outstanding-op limit and a one-entry writeback buffer. Optional check logic: FPU_ISSUE_RD_CHECK_EN.
module fpu_issue_scoreboard #(
    parameter int fp_decode_width_p = 18,
    parameter int data_width_p      = 32,
    parameter int reg_addr_width_p  = 5,
    parameter int max_outstanding_p = 4
) (
    input  logic                         clk_i,
    input  logic                         reset_i,

    input  logic                         v_i,
    input  logic [fp_decode_width_p-1:0] fp_decode_i,
    input  logic [reg_addr_width_p-1:0]  rd_i,
    input  logic [reg_addr_width_p-1:0]  rs1_i,
    input  logic [reg_addr_width_p-1:0]  rs2_i,
    input  logic [data_width_p-1:0]      a_i,
    input  logic [data_width_p-1:0]      b_i,
    output logic                         ready_o,

    output logic                         fpu_v_o,
    output logic [fp_decode_width_p-1:0] fpu_fp_decode_o,
    output logic [data_width_p-1:0]      fpu_a_o,
    output logic [data_width_p-1:0]      fpu_b_o,
    output logic [reg_addr_width_p-1:0]  fpu_rd_o,
    input  logic                         fpu_ready_i,

    input  logic                         fpu_v_i,
    input  logic [data_width_p-1:0]      fpu_z_i,
    input  logic [reg_addr_width_p-1:0]  fpu_rd_i,
    output logic                         fpu_yumi_o,

    output logic                         wb_v_o,
    output logic [reg_addr_width_p-1:0]  wb_rd_o,
    output logic [data_width_p-1:0]      wb_data_o,
    input  logic                         wb_yumi_i,

    output logic                         idle_o,
    output logic                         error_o
);

    localparam int num_regs_lp    = 1 << reg_addr_width_p;
    localparam int count_width_lp = $clog2(max_outstanding_p + 1);
    localparam logic [count_width_lp-1:0] max_count_lp = count_width_lp'(max_outstanding_p);

    logic [num_regs_lp-1:0]    busy_r, busy_n;
    logic [count_width_lp-1:0] count_r, count_n;
    logic                      hazard;
    logic                      issue_fire;
    logic                      wb_fire;

    assign hazard     = busy_r[rd_i] | busy_r[rs1_i] | busy_r[rs2_i];
    assign fpu_v_o    = v_i & ~hazard & (count_r < max_count_lp);
    assign ready_o    = fpu_v_o & fpu_ready_i;
    assign issue_fire = ready_o;

    assign fpu_fp_decode_o = fp_decode_i;
    assign fpu_a_o         = a_i;
    assign fpu_b_o         = b_i;
    assign fpu_rd_o        = rd_i;

    // One-entry buffer: a result may enter in the same cycle the regfile drains the old one.
    assign fpu_yumi_o = fpu_v_i & (~wb_v_o | wb_yumi_i);
    assign wb_fire    = wb_v_o & wb_yumi_i;

    assign idle_o = (count_r == '0) & ~wb_v_o;

    // Set and clear never address the same rd, since issue to a busy rd is blocked.
    always_comb begin
        busy_n = busy_r;
        if (wb_fire)
            busy_n[wb_rd_o] = 1'b0;
        if (issue_fire)
            busy_n[rd_i] = 1'b1;
    end

    always_comb begin
        count_n = count_r;
        case ({issue_fire, wb_fire})
            2'b10:   count_n = count_r + 1'b1;
            2'b01:   count_n = count_r - 1'b1;
            default: count_n = count_r;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            busy_r  <= '0;
            count_r <= '0;
        end else begin
            busy_r  <= busy_n;
            count_r <= count_n;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wb_v_o    <= 1'b0;
            wb_rd_o   <= '0;
            wb_data_o <= '0;
        end else if (fpu_yumi_o) begin
            wb_v_o    <= 1'b1;
            wb_rd_o   <= fpu_rd_i;
            wb_data_o <= fpu_z_i;
        end else if (wb_fire) begin
            wb_v_o    <= 1'b0;
        end
    end

`ifdef FPU_ISSUE_RD_CHECK_EN
    logic error_r;
    logic rd_err;
    logic cnt_err;

    assign rd_err  = fpu_yumi_o & ~busy_r[fpu_rd_i];
    assign cnt_err = (issue_fire & ~wb_fire & (count_r == max_count_lp)) |
                     (wb_fire & ~issue_fire & (count_r == '0));

    always_ff @(posedge clk_i) begin
        if (reset_i)
            error_r <= 1'b0;
        else if (rd_err | cnt_err)
            error_r <= 1'b1;
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            if (rd_err)
                $error("fpu_issue_scoreboard: result for non-busy rd %0d", fpu_rd_i);
            if (cnt_err)
                $error("fpu_issue_scoreboard: outstanding count over/underflow");
        end
    end
`endif

    assign error_o = error_r;
`else
    assign error_o = 1'b0;
`endif

endmodule

// File: tb/tb_fpu_issue_scoreboard.sv
// Self-checking bench for fpu_issue_scoreboard: table-driven issue vectors plus
// hand-written writeback sequences checked against a queue of expected results.
module tb_fpu_issue_scoreboard;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        v_i;
    logic [17:0] fp_decode_i;
    logic [4:0]  rd_i, rs1_i, rs2_i;
    logic [31:0] a_i, b_i;
    logic        ready_o;
    logic        fpu_v_o;
    logic [17:0] fpu_fp_decode_o;
    logic [31:0] fpu_a_o, fpu_b_o;
    logic [4:0]  fpu_rd_o;
    logic        fpu_ready_i;
    logic        fpu_v_i;
    logic [31:0] fpu_z_i;
    logic [4:0]  fpu_rd_i;
    logic        fpu_yumi_o;
    logic        wb_v_o;
    logic [4:0]  wb_rd_o;
    logic [31:0] wb_data_o;
    logic        wb_yumi_i;
    logic        idle_o;
    logic        error_o;

    fpu_issue_scoreboard dut (
        .clk_i(clk), .reset_i(reset_i),
        .v_i(v_i), .fp_decode_i(fp_decode_i), .rd_i(rd_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
        .a_i(a_i), .b_i(b_i), .ready_o(ready_o),
        .fpu_v_o(fpu_v_o), .fpu_fp_decode_o(fpu_fp_decode_o), .fpu_a_o(fpu_a_o),
        .fpu_b_o(fpu_b_o), .fpu_rd_o(fpu_rd_o), .fpu_ready_i(fpu_ready_i),
        .fpu_v_i(fpu_v_i), .fpu_z_i(fpu_z_i), .fpu_rd_i(fpu_rd_i), .fpu_yumi_o(fpu_yumi_o),
        .wb_v_o(wb_v_o), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o), .wb_yumi_i(wb_yumi_i),
        .idle_o(idle_o), .error_o(error_o)
    );

    always #5 clk = ~clk;

`ifdef FPU_ISSUE_RD_CHECK_EN
    localparam logic err_exp = 1'b1;
`else
    localparam logic err_exp = 1'b0;
`endif

    typedef struct {
        logic       v;
        logic [4:0] rd, rs1, rs2;
        logic       rdy;
        logic       e_fpu_v, e_ready, e_idle;
    } vec_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] z;
    } wb_t;

    vec_t tbl[10];
    wb_t  exp_q[$];
    int   passed = 0;
    int   total  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else
            passed++;
    endtask

    task automatic set_op(input logic v, input logic [4:0] rd, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic rdy);
        v_i = v; rd_i = rd; rs1_i = rs1; rs2_i = rs2; fpu_ready_i = rdy;
    endtask

    task automatic set_res(input logic v, input logic [4:0] rd, input logic [31:0] z);
        fpu_v_i = v; fpu_rd_i = rd; fpu_z_i = z;
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    // Every regfile handshake must match the oldest expected result.
    always @(negedge clk) begin
        #2;
        if (reset_i === 1'b0 && wb_v_o === 1'b1 && wb_yumi_i === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL wb_unexpected: got rd %0d data %0h expected no writeback", wb_rd_o, wb_data_o);
            end else begin
                wb_t e;
                e = exp_q.pop_front();
                chk("wb_rd", {27'd0, wb_rd_o}, {27'd0, e.rd});
                chk("wb_data", wb_data_o, e.z);
            end
        end
    end

    initial begin
        tbl[0] = '{1'b1, 5'd3, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[1] = '{1'b1, 5'd5, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 5'd3, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 5'd6, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 5'd6, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 5'd6, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{1'b1, 5'd6, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[7] = '{1'b1, 5'd0, 5'd6, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[8] = '{1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[9] = '{1'b1, 5'd1, 5'd0, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0};

        reset_i = 1'b1;
        fp_decode_i = '0; a_i = '0; b_i = '0; wb_yumi_i = 1'b0;
        set_op(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        set_res(1'b0, 5'd0, 32'd0);
        repeat (2) nxt();
        reset_i = 1'b0;
        #1;
        chk("rst_idle", {31'd0, idle_o}, 32'd1);
        chk("rst_wb_v", {31'd0, wb_v_o}, 32'd0);
        chk("rst_error", {31'd0, error_o}, 32'd0);
        chk("rst_yumi", {31'd0, fpu_yumi_o}, 32'd0);
        nxt();

        // Issue/hazard vectors: busy becomes {3,6,0}, count 3
        for (int i = 0; i < 10; i++) begin
            set_op(tbl[i].v, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].rdy);
            a_i = 32'hA000_0000 + 32'(i);
            b_i = 32'hB000_0000 + 32'(i);
            fp_decode_i = 18'(i * 3 + 1);
            #1;
            chk($sformatf("vec%0d_fpu_v", i), {31'd0, fpu_v_o}, {31'd0, tbl[i].e_fpu_v});
            chk($sformatf("vec%0d_ready", i), {31'd0, ready_o}, {31'd0, tbl[i].e_ready});
            chk($sformatf("vec%0d_idle", i), {31'd0, idle_o}, {31'd0, tbl[i].e_idle});
            chk($sformatf("vec%0d_rd_copy", i), {27'd0, fpu_rd_o}, {27'd0, tbl[i].rd});
            chk($sformatf("vec%0d_a_copy", i), fpu_a_o, 32'hA000_0000 + 32'(i));
            chk($sformatf("vec%0d_b_copy", i), fpu_b_o, 32'hB000_0000 + 32'(i));
            chk($sformatf("vec%0d_dec_copy", i), {14'd0, fpu_fp_decode_o}, 32'(i * 3 + 1));
            nxt();
        end

        // RAW on rd 3 clears only after its writeback handshake
        set_op(1'b1, 5'd5, 5'd3, 5'd1, 1'b1);
        set_res(1'b1, 5'd3, 32'h3F80_0000);
        wb_yumi_i = 1'b1;
        #1;
        chk("raw_yumi", {31'd0, fpu_yumi_o}, 32'd1);
        chk("raw_blocked0", {31'd0, ready_o}, 32'd0);
        exp_q.push_back('{5'd3, 32'h3F80_0000});
        nxt();
        set_res(1'b0, 5'd0, 32'd0);
        #1;
        chk("raw_wb_v", {31'd0, wb_v_o}, 32'd1);
        chk("raw_blocked1", {31'd0, ready_o}, 32'd0);
        nxt();
        #1;
        chk("raw_wb_drop", {31'd0, wb_v_o}, 32'd0);
        chk("raw_issue", {31'd0, ready_o}, 32'd1);
        nxt();

        // Fill to max_outstanding, then one writeback frees a slot
        set_op(1'b1, 5'd7, 5'd1, 5'd2, 1'b1);
        #1;
        chk("fill_issue", {31'd0, ready_o}, 32'd1);
        nxt();
        set_op(1'b1, 5'd8, 5'd1, 5'd2, 1'b1);
        set_res(1'b1, 5'd6, 32'h4000_0000);
        #1;
        chk("full_fpu_v", {31'd0, fpu_v_o}, 32'd0);
        chk("full_ready", {31'd0, ready_o}, 32'd0);
        chk("full_yumi", {31'd0, fpu_yumi_o}, 32'd1);
        exp_q.push_back('{5'd6, 32'h4000_0000});
        nxt();
        set_res(1'b0, 5'd0, 32'd0);
        #1;
        chk("full_hold", {31'd0, ready_o}, 32'd0);
        nxt();
        #1;
        chk("full_free", {31'd0, ready_o}, 32'd1);
        nxt();
        set_op(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);

        // Stalled regfile back-pressures the FPU, then same-cycle refill
        wb_yumi_i = 1'b0;
        set_res(1'b1, 5'd0, 32'h1111_2222);
        #1;
        chk("stall_first_yumi", {31'd0, fpu_yumi_o}, 32'd1);
        exp_q.push_back('{5'd0, 32'h1111_2222});
        nxt();
        set_res(1'b1, 5'd5, 32'h3333_4444);
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("stall_yumi", {31'd0, fpu_yumi_o}, 32'd0);
            chk("stall_wb_v", {31'd0, wb_v_o}, 32'd1);
            chk("stall_wb_rd", {27'd0, wb_rd_o}, 32'd0);
            chk("stall_wb_data", wb_data_o, 32'h1111_2222);
            nxt();
        end
        wb_yumi_i = 1'b1;
        #1;
        chk("refill_yumi", {31'd0, fpu_yumi_o}, 32'd1);
        exp_q.push_back('{5'd5, 32'h3333_4444});
        nxt();
        set_res(1'b0, 5'd0, 32'd0);
        #1;
        chk("refill_wb_v", {31'd0, wb_v_o}, 32'd1);
        chk("refill_wb_rd", {27'd0, wb_rd_o}, 32'd5);
        nxt();
        wb_yumi_i = 1'b0;
        #1;
        chk("drained_wb_v", {31'd0, wb_v_o}, 32'd0);
        chk("busy_not_idle", {31'd0, idle_o}, 32'd0);
        nxt();

        // Reset mid-flight with two ops outstanding
        reset_i = 1'b1;
        nxt();
        reset_i = 1'b0;
        set_op(1'b1, 5'd7, 5'd8, 5'd0, 1'b0);
        #1;
        chk("midrst_idle", {31'd0, idle_o}, 32'd1);
        chk("midrst_wb_v", {31'd0, wb_v_o}, 32'd0);
        chk("midrst_busy_clear", {31'd0, fpu_v_o}, 32'd1);
        chk("midrst_no_fire", {31'd0, ready_o}, 32'd0);
        nxt();

        // rd 4..7 fill the scoreboard; fifth op waits for one writeback
        for (int r = 4; r < 8; r++) begin
            set_op(1'b1, 5'(r), 5'd1, 5'd2, 1'b1);
            #1;
            chk($sformatf("fill4_r%0d", r), {31'd0, ready_o}, 32'd1);
            nxt();
        end
        set_op(1'b1, 5'd9, 5'd1, 5'd2, 1'b1);
        set_res(1'b1, 5'd4, 32'h4040_0000);
        wb_yumi_i = 1'b1;
        #1;
        chk("fifth_blocked", {31'd0, fpu_v_o}, 32'd0);
        exp_q.push_back('{5'd4, 32'h4040_0000});
        nxt();
        set_res(1'b0, 5'd0, 32'd0);
        #1;
        chk("fifth_still_blocked", {31'd0, ready_o}, 32'd0);
        nxt();
        #1;
        chk("fifth_issue", {31'd0, ready_o}, 32'd1);
        nxt();
        set_op(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);

        // Drain back-to-back
        for (int r = 5; r < 10; r++) begin
            if (r == 8) continue;
            set_res(1'b1, 5'(r), 32'h5000_0000 + 32'(r));
            #1;
            chk($sformatf("drain_yumi_r%0d", r), {31'd0, fpu_yumi_o}, 32'd1);
            exp_q.push_back('{5'(r), 32'h5000_0000 + 32'(r)});
            nxt();
        end
        set_res(1'b0, 5'd0, 32'd0);
        nxt();
        wb_yumi_i = 1'b0;
        #1;
        chk("drain_idle", {31'd0, idle_o}, 32'd1);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        chk("error_clean", {31'd0, error_o}, 32'd0);
        nxt();

        // Result for a register that was never issued
        set_res(1'b1, 5'd9, 32'hDEAD_BEEF);
        nxt();
        set_res(1'b0, 5'd0, 32'd0);
        #1;
        chk("stray_error", {31'd0, error_o}, {31'd0, err_exp});
        nxt();
        nxt();
        #1;
        chk("stray_error_sticky", {31'd0, error_o}, {31'd0, err_exp});

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
